// File: rtl/shader_pixel_gen.sv
// shader_pixel_gen: three-stage procedural pixel generator with per-frame pattern latch.
// Optional macro SHADER_ANIM_EN scrolls every pattern by the frame counter.
`default_nettype none

module shader_pixel_gen #(
    parameter int H_CENTER       = 320,
    parameter int V_CENTER       = 240,
    parameter int VS_ACTIVE_HIGH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  shader_select,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [23:0] rgb,
    output logic [7:0]  frame_cnt,
    output logic [3:0]  active_shader
);

    localparam logic       VS_IDLE = (VS_ACTIVE_HIGH == 0);
    localparam logic [9:0] HC      = 10'(H_CENTER);
    localparam logic [9:0] VC      = 10'(V_CENTER);

    // Frame tracking
    logic       vs_prev_q;
    logic [7:0] frame_cnt_q;
    logic [3:0] active_shader_q;
    logic       vs_edge;
    logic [7:0] t;

    assign vs_edge = (vsync_in != VS_IDLE) && (vs_prev_q == VS_IDLE);

`ifdef SHADER_ANIM_EN
    assign t = frame_cnt_q;
`else
    assign t = 8'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q       <= VS_IDLE;
            frame_cnt_q     <= 8'd0;
            active_shader_q <= 4'd0;
        end else begin
            vs_prev_q <= vsync_in;
            if (vs_edge) begin
                frame_cnt_q     <= frame_cnt_q + 8'd1;
                active_shader_q <= shader_select;
            end
        end
    end

    // Stage 1: capture pixel coordinates together with the pattern and time base
    logic [9:0] x1_q, y1_q;
    logic [7:0] t1_q;
    logic [3:0] sel1_q;
    logic       de1_q, hs1_q, vs1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q   <= 10'd0;
            y1_q   <= 10'd0;
            t1_q   <= 8'd0;
            sel1_q <= 4'd0;
            de1_q  <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= VS_IDLE;
        end else begin
            x1_q   <= x;
            y1_q   <= y;
            t1_q   <= t;
            sel1_q <= active_shader_q;
            de1_q  <= de_in;
            hs1_q  <= hsync_in;
            vs1_q  <= vsync_in;
        end
    end

    // Stage 2: coordinate arithmetic shared by all patterns
    logic [9:0]  u, v, dx, dy, d;
    logic [10:0] s;
    logic [7:0]  xo;
    logic        w_unused_bits;

    assign u  = x1_q + {2'b00, t1_q};
    assign v  = y1_q + {2'b00, t1_q};
    assign dx = (x1_q >= HC) ? (x1_q - HC) : (HC - x1_q);
    assign dy = (y1_q >= VC) ? (y1_q - VC) : (VC - y1_q);
    assign d  = dx + dy + {2'b00, t1_q};
    assign s  = {1'b0, x1_q} + {1'b0, y1_q} + {3'b000, t1_q};
    assign xo = (x1_q[7:0] ^ y1_q[7:0]) + t1_q;

    assign w_unused_bits = ^{u[1:0], v[9], v[0], d[9], s[10], s[0]};

    logic [7:0] ug_q, vg_q, xo_q;
    logic [8:0] d_q, s_q;
    logic       chk_q;
    logic [3:0] sel2_q;
    logic       de2_q, hs2_q, vs2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ug_q   <= 8'd0;
            vg_q   <= 8'd0;
            xo_q   <= 8'd0;
            d_q    <= 9'd0;
            s_q    <= 9'd0;
            chk_q  <= 1'b0;
            sel2_q <= 4'd0;
            de2_q  <= 1'b0;
            hs2_q  <= 1'b0;
            vs2_q  <= VS_IDLE;
        end else begin
            ug_q   <= u[9:2];
            vg_q   <= v[8:1];
            xo_q   <= xo;
            d_q    <= d[8:0];
            s_q    <= s[9:1];
            chk_q  <= u[5] ^ y1_q[5];
            sel2_q <= sel1_q;
            de2_q  <= de1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    // Stage 3: pattern select and blanking
    logic [23:0] rgb_d;

    always_comb begin
        rgb_d = 24'h808080;
        case (sel2_q)
            4'd0:    rgb_d = {ug_q, 8'h00, ~ug_q};
            4'd1:    rgb_d = {8'h00, vg_q, ~vg_q};
            4'd2:    rgb_d = {d_q[8:1], d_q[7:0], ~d_q[8:1]};
            4'd3:    rgb_d = chk_q ? 24'hFFFFFF : 24'h000000;
            4'd4:    rgb_d = {s_q[7:0], s_q[8:1], 8'h80};
            4'd5:    rgb_d = {xo_q, xo_q, xo_q};
            default: rgb_d = 24'h808080;
        endcase
        if (!de2_q) begin
            rgb_d = 24'h000000;
        end
    end

    logic [23:0] rgb_q;
    logic        de_out_q, hs_out_q, vs_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q    <= 24'd0;
            de_out_q <= 1'b0;
            hs_out_q <= 1'b0;
            vs_out_q <= VS_IDLE;
        end else begin
            rgb_q    <= rgb_d;
            de_out_q <= de2_q;
            hs_out_q <= hs2_q;
            vs_out_q <= vs2_q;
        end
    end

    assign rgb           = rgb_q;
    assign de_out        = de_out_q;
    assign hsync_out     = hs_out_q;
    assign vsync_out     = vs_out_q;
    assign frame_cnt     = frame_cnt_q;
    assign active_shader = active_shader_q;

endmodule

`default_nettype wire

// File: tb/tb_shader_pixel_gen.sv
// Directed self-checking bench for shader_pixel_gen (default parameters).
`default_nettype none

module tb_shader_pixel_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  shader_select = 4'd0;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic        de_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        de_out, hsync_out, vsync_out;
    logic [23:0] rgb;
    logic [7:0]  frame_cnt;
    logic [3:0]  active_shader;

    int n_chk  = 0;
    int n_fail = 0;
    int nf     = 0;

    shader_pixel_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .shader_select (shader_select),
        .x             (x),
        .y             (y),
        .de_in         (de_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .de_out        (de_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .rgb           (rgb),
        .frame_cnt     (frame_cnt),
        .active_shader (active_shader)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle pixel; result due three edges after it is sampled, blank the cycle after.
    task automatic pixel(input string tag, input logic [9:0] px, input logic [9:0] py,
                         input logic [23:0] exp);
        x = px; y = py; de_in = 1'b1;
        tick();
        de_in = 1'b0;
        tick();
        tick();
        chk({tag, "_rgb"}, rgb, exp);
        chk({tag, "_de"}, {23'd0, de_out}, 24'd1);
        tick();
        chk({tag, "_blank_rgb"}, rgb, 24'h000000);
        chk({tag, "_blank_de"}, {23'd0, de_out}, 24'd0);
    endtask

    task automatic vs_pulse(input logic [3:0] sel);
        shader_select = sel;
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
        nf++;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_rgb", rgb, 24'h0);
        chk("rst_de", {23'd0, de_out}, 24'd0);
        chk("rst_hs", {23'd0, hsync_out}, 24'd0);
        chk("rst_vs", {23'd0, vsync_out}, 24'd0);
        chk("rst_frame", {16'd0, frame_cnt}, 24'd0);
        chk("rst_shader", {20'd0, active_shader}, 24'd0);
        rst_n = 1'b1;
        tick();

        // Horizontal gradient, then a mid-frame select change that must be ignored
        pixel("p0_x100", 10'd100, 10'd0, 24'h1900E6);
        shader_select = 4'd3;
        pixel("p0_hold", 10'd100, 10'd0, 24'h1900E6);
        chk("hold_shader", {20'd0, active_shader}, 24'd0);
        vs_pulse(4'd3);
        chk("latch_shader", {20'd0, active_shader}, 24'd3);
        pixel("p3_x32", 10'd32, 10'd0, 24'hFFFFFF);
        pixel("p3_x0", 10'd0, 10'd0, 24'h000000);

        vs_pulse(4'd1);
        pixel("p1_y100", 10'd0, 10'd100, 24'h0032CD);

        vs_pulse(4'd2);
        pixel("p2_center", 10'd320, 10'd240, 24'h0000FF);
        pixel("p2_near", 10'd330, 10'd235, 24'h070FF8);
        pixel("p2_origin", 10'd0, 10'd0, 24'h1830E7);

        vs_pulse(4'd4);
        pixel("p4_mid", 10'd100, 10'd200, 24'h964B80);
        pixel("p4_max", 10'd1023, 10'd1023, 24'hFFFF80);

        vs_pulse(4'd5);
        pixel("p5_a", 10'd243, 10'd53, 24'hC6C6C6);
        pixel("p5_b", 10'd426, 10'd597, 24'hFFFFFF);

        vs_pulse(4'd9);
        pixel("p9", 10'd5, 10'd5, 24'h808080);

        // Sync pass-through latency
        hsync_in = 1'b1;
        tick();
        hsync_in = 1'b0;
        tick(); tick();
        chk("hs_out_hi", {23'd0, hsync_out}, 24'd1);
        tick();
        chk("hs_out_lo", {23'd0, hsync_out}, 24'd0);
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        nf++;
        tick(); tick();
        chk("vs_out_hi", {23'd0, vsync_out}, 24'd1);
        tick();
        chk("vs_out_lo", {23'd0, vsync_out}, 24'd0);

        // Frame counter wrap
        chk("frame_mid", {16'd0, frame_cnt}, 24'(nf));
        while (nf < 256) vs_pulse(4'd0);
        chk("frame_wrap", {16'd0, frame_cnt}, 24'd0);
        vs_pulse(4'd0);
        chk("frame_one", {16'd0, frame_cnt}, 24'd1);

        // Asynchronous reset mid-line
        vs_pulse(4'd5);
        x = 10'd243; y = 10'd53; de_in = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("arst_rgb", rgb, 24'h0);
        chk("arst_de", {23'd0, de_out}, 24'd0);
        chk("arst_frame", {16'd0, frame_cnt}, 24'd0);
        chk("arst_shader", {20'd0, active_shader}, 24'd0);
        de_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_frame", {16'd0, frame_cnt}, 24'd0);
        chk("rel_shader", {20'd0, active_shader}, 24'd0);
        pixel("resume_p0", 10'd100, 10'd0, 24'h1900E6);

        // Four frames later: scrolled only when animation is built in
        for (int i = 0; i < 4; i++) vs_pulse(4'd0);
        chk("frame_four", {16'd0, frame_cnt}, 24'd4);
`ifdef SHADER_ANIM_EN
        pixel("anim_t4", 10'd100, 10'd0, 24'h1A00E5);
`else
        pixel("static_t4", 10'd100, 10'd0, 24'h1900E6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shader_pixel_gen.md
SHADER_PIXEL_GEN -- requirements
Module: shader_pixel_gen

Interface
REQ-001 SHALL have parameter H_CENTER, default 320, horizontal centre for the radial pattern.
REQ-002 SHALL have parameter V_CENTER, default 240, vertical centre for the radial pattern.
REQ-003 SHALL have parameter VS_ACTIVE_HIGH, default 1, vsync_in polarity (1 = high active, 0 = low active).
REQ-004 SHALL have port clk, input, 1 bit: pixel clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low; clock clk.
REQ-006 SHALL have port shader_select, input, 4 bits: requested pattern from the demo controller, may change at any cycle.
REQ-007 SHALL have port x, input, 10 bits: active-area column.
REQ-008 SHALL have port y, input, 10 bits: active-area row.
REQ-009 SHALL have ports de_in, hsync_in and vsync_in, input, 1 bit each: timing signals aligned with x and y.
REQ-010 SHALL have ports de_out, hsync_out and vsync_out, output, 1 bit each: timing signals delayed to match rgb.
REQ-011 SHALL have port rgb, output, 24 bits: {R,G,B} pixel, 8 bits per channel.
REQ-012 SHALL have port frame_cnt, output, 8 bits: frame counter.
REQ-013 SHALL have port active_shader, output, 4 bits: pattern currently being rendered.

Function
REQ-014 SHALL detect the vsync active edge as vsync_in going to its active level, with the previous vsync_in value registered.
REQ-015 SHALL increment frame_cnt on each vsync active edge, wrapping from 255 to 0.
REQ-016 SHALL load active_shader from shader_select only on a vsync active edge; changes during a frame SHALL be ignored.
REQ-017 SHALL form t = frame_cnt when animation is enabled, otherwise t = 0. Then u = (x+t) mod 1024, v = (y+t) mod 1024, and d = |x-H_CENTER| + |y-V_CENTER| + t truncated to 10 bits.
REQ-018 Pattern 0 (horizontal gradient): R=u[9:2], G=00, B=~u[9:2].
REQ-019 Pattern 1 (vertical gradient): R=00, G=v[8:1], B=~v[8:1].
REQ-020 Pattern 2 (radial): R=d[8:1], G=d[7:0], B=~d[8:1].
REQ-021 Pattern 3 (checkerboard): FFFFFF when u[5]^y[5]=1, otherwise 000000.
REQ-022 Pattern 4 (diagonal bands): s = x+y+t as 11 bits; R=s[8:1], G=s[9:2], B=80.
REQ-023 Pattern 5 (XOR): R=G=B=(x[7:0]^y[7:0])+t, mod 256.
REQ-024 Patterns 6-15 SHALL output 808080.
REQ-025 SHALL be a 3-stage pipeline: inputs sampled at edge N appear on de_out, hsync_out, vsync_out and rgb at edge N+3.
REQ-026 SHALL drive rgb=000000 whenever de_out=0.
REQ-027 SHALL render the whole pixel with the active_shader value sampled at stage 1, so a frame never mixes patterns.

Reset
REQ-028 While rst_n=0: frame_cnt=0, active_shader=0, rgb=0, de_out=0, hsync_out=0, all pipeline registers cleared.
REQ-029 Reset SHALL force vsync_out to the inactive level and the previous-vsync register to the inactive level, so that vsync_in active in the first cycle after release counts as an edge.
REQ-030 Reset asserted mid-frame SHALL take effect immediately; output SHALL resume within 3 cycles of release.

Configuration
REQ-031 With macro SHADER_ANIM_EN defined, t SHALL equal frame_cnt and patterns scroll one step per frame.
REQ-032 Without SHADER_ANIM_EN, t SHALL be 0 and patterns are static; frame_cnt SHALL still count.

Verification
REQ-033 Select=0, t=0, x=100, de_in=1 -> rgb=1900E6 exactly 3 cycles later, with de_out=1 on the same cycle.
REQ-034 Select=2, x=320, y=240, t=0 -> rgb=0000FF; select=3 with x=32, y=0, t=0 -> FFFFFF; x=0 -> 000000.
REQ-035 Select changed 0->3 mid-frame -> pattern 0 continues until the next vsync edge, then active_shader=3.
REQ-036 Select=9, then vsync edge -> rgb=808080 on every pixel where de_out=1, and 000000 where de_out=0.
REQ-037 256 vsync pulses from reset -> frame_cnt=0. With SHADER_ANIM_EN at frame_cnt=4, select=0, x=100 -> R=1A.
REQ-038 rst_n pulsed low mid-line -> all outputs 0 asynchronously; after release, frame_cnt=0 and active_shader=0.
